sata_rx_prim_decode: RTL and testbench

//  75 MHz link-side receive stage directly after the phy interface: consumes the 33-bit {rx_k, dword} stream,

---
 rtl/sata_rx_prim_decode.sv | 187 ++++++++++++++++++
 tb/tb_sata_rx_prim_decode.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_rx_prim_decode.sv
// SATA link receive stage: decodes primitives, strips ALIGN, expands CONT repeats
// and extracts FIS payload dwords between SOF and EOF. All outputs registered.
module sata_rx_prim_decode #(
    parameter int MAX_DWORDS = 2064,
    parameter int LEN_W      = 12
) (
    input  logic             clk,
    input  logic             host_rst_n,
    input  logic             link_up,
    input  logic [31:0]      dev_rx_data,
    input  logic             rx_k,
    output logic [4:0]       prim_cur,
    output logic             prim_new,
    output logic [31:0]      data_out,
    output logic             data_vld,
    output logic             sof_pulse,
    output logic             eof_pulse,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_abort,
    output logic             frame_err,
    output logic             prim_err
);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_HOLD, S_DROP} state_t;

    localparam logic [4:0] P_NONE = 5'd0;
    localparam logic [4:0] P_SYNC = 5'd1;
    localparam logic [4:0] P_SOF  = 5'd4;
    localparam logic [4:0] P_EOF  = 5'd5;
    localparam logic [4:0] P_HOLD = 5'd6;

    localparam logic [31:0] W_CONT  = 32'h9999AA7C;
    localparam logic [31:0] W_ALIGN = 32'h7B4A4ABC;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DWORDS);

    function automatic logic [4:0] decode(input logic [31:0] d);
        case (d)
            32'hB5B5957C: decode = 5'd1;
            32'h5757B57C: decode = 5'd2;
            32'h4A4A957C: decode = 5'd3;
            32'h3737B57C: decode = 5'd4;
            32'hD5D5B57C: decode = 5'd5;
            32'hD5D5AA7C: decode = 5'd6;
            32'h9595AA7C: decode = 5'd7;
            32'h5858B57C: decode = 5'd8;
            32'h5555B57C: decode = 5'd9;
            32'h3535B57C: decode = 5'd10;
            32'h5656B57C: decode = 5'd11;
            32'h3636B57C: decode = 5'd12;
            32'h1717B57C: decode = 5'd13;
            32'h7575957C: decode = 5'd14;
            32'h9595957C: decode = 5'd15;
            32'hF5F5957C: decode = 5'd16;
            default:      decode = P_NONE;
        endcase
    endfunction

    state_t           state;
    logic             cont_active;
    logic [LEN_W-1:0] len;

    logic [4:0] code;
    logic       is_cont;
    logic       is_align;
    logic       is_prim;
    logic       is_unknown;
    logic       is_data;

    always_comb begin
        code       = decode(dev_rx_data);
        is_cont    = rx_k && (dev_rx_data == W_CONT);
        is_align   = rx_k && (dev_rx_data == W_ALIGN);
        is_prim    = rx_k && (code != P_NONE);
        is_unknown = rx_k && !is_cont && !is_align && (code == P_NONE);
        // Under CONT, non-K dwords are scrambled repeats and carry no payload.
        is_data    = !rx_k && !cont_active;
    end

    always_ff @(posedge clk or negedge host_rst_n) begin
        if (!host_rst_n) begin
            state       <= S_IDLE;
            cont_active <= 1'b0;
            len         <= '0;
            prim_cur    <= '0;
            prim_new    <= 1'b0;
            data_out    <= '0;
            data_vld    <= 1'b0;
            sof_pulse   <= 1'b0;
            eof_pulse   <= 1'b0;
            frame_len   <= '0;
            frame_abort <= 1'b0;
            frame_err   <= 1'b0;
            prim_err    <= 1'b0;
        end else if (!link_up) begin
            state       <= S_IDLE;
            cont_active <= 1'b0;
            len         <= '0;
            prim_cur    <= '0;
            prim_new    <= 1'b0;
            data_out    <= '0;
            data_vld    <= 1'b0;
            sof_pulse   <= 1'b0;
            eof_pulse   <= 1'b0;
            frame_len   <= '0;
            frame_abort <= 1'b0;
            frame_err   <= 1'b0;
            prim_err    <= 1'b0;
        end else begin
            prim_new    <= 1'b0;
            data_vld    <= 1'b0;
            sof_pulse   <= 1'b0;
            eof_pulse   <= 1'b0;
            frame_abort <= 1'b0;
            prim_err    <= is_unknown;

            if (is_cont) begin
                cont_active <= 1'b1;
            end else if (is_prim) begin
                cont_active <= 1'b0;
                prim_cur    <= code;
                prim_new    <= (code != prim_cur);
            end

            unique case (state)
                S_IDLE: begin
                    if (is_prim && code == P_SOF) begin
                        state     <= S_FRAME;
                        sof_pulse <= 1'b1;
                        len       <= '0;
                        frame_err <= 1'b0;
                    end else if (is_data) begin
                        prim_err <= 1'b1;
                    end
                end
                S_FRAME, S_HOLD: begin
                    if (is_data) begin
                        if (len == MAX_LEN) begin
                            frame_err <= 1'b1;
                            state     <= S_DROP;
                        end else begin
                            data_vld <= 1'b1;
                            data_out <= dev_rx_data;
                            len      <= len + LEN_W'(1);
                            state    <= S_FRAME;
                        end
                    end else if (is_prim) begin
                        case (code)
                            P_EOF: begin
                                state     <= S_IDLE;
                                eof_pulse <= 1'b1;
                                frame_len <= len;
                            end
                            P_SYNC: begin
                                state       <= S_IDLE;
                                frame_abort <= 1'b1;
                            end
                            P_HOLD: state <= S_HOLD;
                            P_SOF: begin
                                // A SOF while held only releases the hold; in FRAME it restarts.
                                state <= S_FRAME;
                                if (state == S_FRAME) begin
                                    sof_pulse <= 1'b1;
                                    len       <= '0;
                                    frame_err <= 1'b0;
                                end
                            end
                            default: state <= S_FRAME;
                        endcase
                    end
                end
                S_DROP: begin
                    if (is_prim && code == P_EOF) begin
                        state     <= S_IDLE;
                        eof_pulse <= 1'b1;
                        frame_len <= MAX_LEN;
                    end else if (is_prim && code == P_SYNC) begin
                        state       <= S_IDLE;
                        frame_abort <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sata_rx_prim_decode.sv
// Bench for sata_rx_prim_decode: directed vector table, corner-case sequences and
// random traffic checked against a queue-based frame model.
module tb_sata_rx_prim_decode;
    localparam int MAXD = 4;
    localparam int LW   = 3;

    localparam bit [31:0] W_SYNC  = 32'hB5B5957C;
    localparam bit [31:0] W_XRDY  = 32'h5757B57C;
    localparam bit [31:0] W_SOF   = 32'h3737B57C;
    localparam bit [31:0] W_EOF   = 32'hD5D5B57C;
    localparam bit [31:0] W_HOLD  = 32'hD5D5AA7C;
    localparam bit [31:0] W_RIP   = 32'h5555B57C;
    localparam bit [31:0] W_CONT  = 32'h9999AA7C;
    localparam bit [31:0] W_ALIGN = 32'h7B4A4ABC;

    logic          clk = 1'b0;
    logic          host_rst_n;
    logic          link_up;
    logic [31:0]   dev_rx_data;
    logic          rx_k;
    logic [4:0]    prim_cur;
    logic          prim_new;
    logic [31:0]   data_out;
    logic          data_vld;
    logic          sof_pulse;
    logic          eof_pulse;
    logic [LW-1:0] frame_len;
    logic          frame_abort;
    logic          frame_err;
    logic          prim_err;

    always #5 clk = ~clk;

    sata_rx_prim_decode #(.MAX_DWORDS(MAXD), .LEN_W(LW)) dut (
        .clk(clk), .host_rst_n(host_rst_n), .link_up(link_up),
        .dev_rx_data(dev_rx_data), .rx_k(rx_k),
        .prim_cur(prim_cur), .prim_new(prim_new), .data_out(data_out), .data_vld(data_vld),
        .sof_pulse(sof_pulse), .eof_pulse(eof_pulse), .frame_len(frame_len),
        .frame_abort(frame_abort), .frame_err(frame_err), .prim_err(prim_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int vld_seen = 0;

    bit [31:0] pw [16] = '{32'hB5B5957C, 32'h5757B57C, 32'h4A4A957C, 32'h3737B57C,
                           32'hD5D5B57C, 32'hD5D5AA7C, 32'h9595AA7C, 32'h5858B57C,
                           32'h5555B57C, 32'h3535B57C, 32'h5656B57C, 32'h3636B57C,
                           32'h1717B57C, 32'h7575957C, 32'h9595957C, 32'hF5F5957C};
    int code_of [bit [31:0]];

    // Model: current primitive, CONT flag, and the open frame's payload as a queue.
    int        m_prim;
    bit        m_cont, m_in, m_held, m_drop, m_ferr;
    bit [31:0] m_q [$];
    bit [31:0] m_dout;
    int        m_flen;
    bit        e_new, e_vld, e_sof, e_eof, e_abort, e_perr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prim = 0; m_cont = 0; m_in = 0; m_held = 0; m_drop = 0; m_ferr = 0;
        m_q.delete(); m_dout = '0; m_flen = 0;
        {e_new, e_vld, e_sof, e_eof, e_abort, e_perr} = '0;
    endtask

    task automatic start_frame();
        m_q.delete(); e_sof = 1; m_ferr = 0; m_in = 1; m_held = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit k, input bit [31:0] d);
        int c;
        {e_new, e_vld, e_sof, e_eof, e_abort, e_perr} = '0;
        if (k && d == W_CONT) begin m_cont = 1; return; end
        if (k && d == W_ALIGN) return;
        if (k && !code_of.exists(d)) begin e_perr = 1; return; end
        if (!k) begin
            if (m_cont) return;
            if (!m_in) begin e_perr = 1; return; end
            if (m_drop) return;
            if (m_q.size() == MAXD) begin m_ferr = 1; m_drop = 1; return; end
            m_q.push_back(d); m_dout = d; e_vld = 1; m_held = 0;
            return;
        end
        c = code_of[d];
        m_cont = 0;
        e_new = (c != m_prim);
        m_prim = c;
        if (!m_in) begin
            if (c == 4) start_frame();
            return;
        end
        if (c == 5) begin e_eof = 1; m_flen = m_q.size(); m_in = 0; end
        else if (c == 1) begin e_abort = 1; m_in = 0; end
        else if (m_drop) begin end
        else if (c == 6) m_held = 1;
        else if (c == 4 && !m_held) start_frame();
        else m_held = 0;
    endtask

    task automatic check_model();
        chk("prim_cur", 32'(prim_cur), 32'(m_prim));
        chk("prim_new", 32'(prim_new), 32'(e_new));
        chk("data_vld", 32'(data_vld), 32'(e_vld));
        if (e_vld) chk("data_out", data_out, m_dout);
        chk("sof_pulse", 32'(sof_pulse), 32'(e_sof));
        chk("eof_pulse", 32'(eof_pulse), 32'(e_eof));
        if (e_eof) chk("frame_len", 32'(frame_len), 32'(m_flen));
        chk("frame_abort", 32'(frame_abort), 32'(e_abort));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("prim_err", 32'(prim_err), 32'(e_perr));
    endtask

    task automatic step(input bit k, input bit [31:0] d);
        rx_k = k; dev_rx_data = d;
        @(posedge clk); #1;
        if (data_vld) vld_seen++;
        model_step(k, d);
        check_model();
    endtask

    task automatic flush();
        link_up = 1'b0; rx_k = 1'b0; dev_rx_data = '0;
        @(posedge clk); #1;
        model_reset();
        check_model();
        link_up = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_prim_cur"}, 32'(prim_cur), 32'd0);
        chk({nm, "_data_out"}, data_out, 32'd0);
        chk({nm, "_frame_len"}, 32'(frame_len), 32'd0);
        chk({nm, "_flags"}, 32'({prim_new, data_vld, sof_pulse, eof_pulse, frame_abort, frame_err, prim_err}), 32'd0);
    endtask

    typedef struct {
        bit k; bit [31:0] d; bit [4:0] prim; bit pnew; bit vld;
        bit sof; bit eof; bit [LW-1:0] flen; bit abort; bit perr;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(bit k, bit [31:0] d, bit [4:0] p, bit pn, bit v,
                                bit s, bit e, bit [LW-1:0] fl, bit ab, bit pe);
        vec_t r;
        r.k = k; r.d = d; r.prim = p; r.pnew = pn; r.vld = v;
        r.sof = s; r.eof = e; r.flen = fl; r.abort = ab; r.perr = pe;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) code_of[pw[i]] = i + 1;

        //            k  data          prim pn vld sof eof len ab perr
        tbl.push_back(mk(1, W_SOF,        4, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h11111111, 4, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h22222222, 4, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h33333333, 4, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, W_EOF,        5, 1, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(1, W_XRDY,       2, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, W_CONT,       2, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 32'h5A5A0000 + 32'(i), 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, W_ALIGN,      2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0F0F0F0F, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, W_RIP,        9, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, W_SOF,        4, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0A0A0A0A, 4, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0B0B0B0B, 4, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, W_SYNC,       1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, W_SYNC,       1, 0, 0, 0, 0, 0, 0, 0));

        host_rst_n = 1'b0; link_up = 1'b0; rx_k = 1'b0; dev_rx_data = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        host_rst_n = 1'b1; link_up = 1'b1;

        foreach (tbl[i]) begin
            rx_k = tbl[i].k; dev_rx_data = tbl[i].d;
            @(posedge clk); #1;
            chk($sformatf("v%0d_prim_cur", i), 32'(prim_cur), 32'(tbl[i].prim));
            chk($sformatf("v%0d_prim_new", i), 32'(prim_new), 32'(tbl[i].pnew));
            chk($sformatf("v%0d_data_vld", i), 32'(data_vld), 32'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("v%0d_data_out", i), data_out, tbl[i].d);
            chk($sformatf("v%0d_sof", i), 32'(sof_pulse), 32'(tbl[i].sof));
            chk($sformatf("v%0d_eof", i), 32'(eof_pulse), 32'(tbl[i].eof));
            if (tbl[i].eof) chk($sformatf("v%0d_frame_len", i), 32'(frame_len), 32'(tbl[i].flen));
            chk($sformatf("v%0d_abort", i), 32'(frame_abort), 32'(tbl[i].abort));
            chk($sformatf("v%0d_prim_err", i), 32'(prim_err), 32'(tbl[i].perr));
        end

        // HOLD then CONT: junk discarded, repeated HOLD ends CONT, data B resumes frame.
        flush();
        vld_seen = 0;
        step(1, W_SOF); step(0, 32'hAAAA0001); step(1, W_HOLD); step(1, W_CONT);
        for (int i = 0; i < 4; i++) step(0, $urandom);
        step(1, W_HOLD); step(0, 32'hBBBB0002); step(1, W_EOF);
        chk("holdcont_vld_count", 32'(vld_seen), 32'd2);
        chk("holdcont_eof", 32'(eof_pulse), 32'd1);
        chk("holdcont_len", 32'(frame_len), 32'd2);

        // Oversize frame.
        vld_seen = 0;
        step(1, W_SOF);
        for (int i = 0; i < 6; i++) step(0, 32'h10000000 + 32'(i));
        chk("ovf_vld_count", 32'(vld_seen), 32'(MAXD));
        step(1, W_EOF);
        chk("ovf_eof", 32'(eof_pulse), 32'd1);
        chk("ovf_err", 32'(frame_err), 32'd1);
        chk("ovf_len", 32'(frame_len), 32'(MAXD));

        // link_up low for one clock mid-frame.
        step(1, W_SOF); step(0, 32'h12345678);
        flush();
        step(0, 32'h87654321);
        chk("linkdn_idle_perr", 32'(prim_err), 32'd1);
        step(1, W_EOF);
        chk("linkdn_no_eof", 32'(eof_pulse), 32'd0);

        // Asynchronous reset mid-frame.
        step(1, W_SOF); step(0, 32'h55AA55AA);
        #2 host_rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        host_rst_n = 1'b1;
        model_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 35)      step(0, $urandom);
            else if (r < 45) step(1, W_SOF);
            else if (r < 53) step(1, W_EOF);
            else if (r < 57) step(1, W_SYNC);
            else if (r < 65) step(1, W_HOLD);
            else if (r < 72) step(1, W_CONT);
            else if (r < 77) step(1, W_ALIGN);
            else if (r < 80) step(1, $urandom);
            else if (r < 99) step(1, pw[$urandom_range(0, 15)]);
            else             flush();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
